record_bcd_capture: RTL and testbench

//  Captures a binary record value (e.g. best lap time / distance) on request and converts it to
//  7 BCD digits with a sequential shift-add-3 (double-dabble) engine. Drives led1..led7 and
//  has_record of the VGA record-overlay stage directly downstream. Displayed digits change

---
 rtl/record_bcd_capture.sv | 118 +++++++++++
 tb/tb_record_bcd_capture.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/record_bcd_capture.sv
// Captures a binary record value and converts it to 7 BCD display digits with a
// sequential double-dabble engine. Optional RECORD_BEST_EN keeps only improving records.
module record_bcd_capture #(
    parameter int BIN_W  = 24,
    parameter int DIGITS = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rec_req,
    input  logic [BIN_W-1:0] rec_value,
    input  logic             clr_record,
    output logic             busy,
    output logic             rec_done,
    output logic             overflow,
    output logic             has_record,
    output logic [3:0]       led1,
    output logic [3:0]       led2,
    output logic [3:0]       led3,
    output logic [3:0]       led4,
    output logic [3:0]       led5,
    output logic [3:0]       led6,
    output logic [3:0]       led7
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W);
    localparam logic [BIN_W-1:0] SAT_VAL = BIN_W'(9_999_999);

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t             state_reg;
    logic [BIN_W-1:0]   shift_reg;
    logic [BCD_W-1:0]   scratch_reg;
    logic [BCD_W-1:0]   digits_reg;
    logic [BCD_W-1:0]   adj_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic               sat_reg;
    logic               accept;

`ifdef RECORD_BEST_EN
    logic [BIN_W-1:0]   best_reg;
    assign accept = rec_req && (!has_record || (rec_value < best_reg));
`else
    assign accept = rec_req;
`endif

    // Add-3 correction on every nibble that would overflow a decimal digit when doubled
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign adj_next[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                       ? scratch_reg[4*gi +: 4] + 4'd3
                                       : scratch_reg[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n || clr_record) begin
            state_reg   <= IDLE;
            busy        <= 1'b0;
            rec_done    <= 1'b0;
            overflow    <= 1'b0;
            has_record  <= 1'b0;
            digits_reg  <= '0;
            shift_reg   <= '0;
            scratch_reg <= '0;
            cnt_reg     <= '0;
            sat_reg     <= 1'b0;
`ifdef RECORD_BEST_EN
            best_reg    <= '0;
`endif
        end else begin
            rec_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        // Out-of-range values are clamped up front so the engine yields all 9s
                        shift_reg   <= (rec_value > SAT_VAL) ? SAT_VAL : rec_value;
                        sat_reg     <= (rec_value > SAT_VAL);
                        scratch_reg <= '0;
                        cnt_reg     <= CNT_W'(BIN_W - 1);
                        busy        <= 1'b1;
                        state_reg   <= CONVERT;
`ifdef RECORD_BEST_EN
                        best_reg    <= rec_value;
`endif
                    end
                end
                CONVERT: begin
                    {scratch_reg, shift_reg} <= {adj_next[BCD_W-2:0], shift_reg, 1'b0};
                    if (cnt_reg == '0) begin
                        state_reg <= COMMIT;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                COMMIT: begin
                    digits_reg <= scratch_reg;
                    overflow   <= sat_reg;
                    has_record <= 1'b1;
                    rec_done   <= 1'b1;
                    busy       <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign led1 = digits_reg[3:0];
    assign led2 = digits_reg[7:4];
    assign led3 = digits_reg[11:8];
    assign led4 = digits_reg[15:12];
    assign led5 = digits_reg[19:16];
    assign led6 = digits_reg[23:20];
    assign led7 = digits_reg[27:24];

endmodule

// File: tb/tb_record_bcd_capture.sv
// Scoreboard bench for record_bcd_capture: a driver predicts each commit from decimal
// arithmetic and queues it; a monitor checks every cycle against the queue and display model.
module tb_record_bcd_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rec_req = 1'b0;
    logic [23:0] rec_value = '0;
    logic        clr_record = 1'b0;
    logic        busy, rec_done, overflow, has_record;
    logic [3:0]  led1, led2, led3, led4, led5, led6, led7;

    always #5 clk = ~clk;

    record_bcd_capture dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rec_req    (rec_req),
        .rec_value  (rec_value),
        .clr_record (clr_record),
        .busy       (busy),
        .rec_done   (rec_done),
        .overflow   (overflow),
        .has_record (has_record),
        .led1       (led1),
        .led2       (led2),
        .led3       (led3),
        .led4       (led4),
        .led5       (led5),
        .led6       (led6),
        .led7       (led7)
    );

    typedef struct {
        logic [27:0] leds;
        bit          ovf;
        int          commit;
    } exp_t;

    exp_t        q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          edge_cnt = 0;
    bit          mon_en = 0;
    logic [27:0] exp_disp = '0;
    bit          exp_has = 0;
    bit          exp_ovf = 0;

    bit          inflight = 0;
    int          commit_edge = 0;
    bit          model_has = 0;
    logic [23:0] model_best = '0;

    function automatic logic [27:0] to_bcd(input logic [23:0] v);
        logic [27:0] r;
        int vv;
        vv = (v > 24'd9999999) ? 9999999 : int'(v);
        r = '0;
        for (int i = 0; i < 7; i++) begin
            r[4*i +: 4] = 4'(vv % 10);
            vv = vv / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s at edge %0d: got 'h%0h, expected 'h%0h", name, edge_cnt, act, exp);
        end
    endtask

    // One clock of stimulus; the reference model is updated on the edge that samples it.
    task automatic step(input bit req, input logic [23:0] val, input bit clr, input bit rst);
        bit busy_model;
        bit ok;
        @(negedge clk);
        rec_req    = req;
        rec_value  = val;
        clr_record = clr;
        rst_n      = !rst;
        @(posedge clk);
        edge_cnt++;
        busy_model = inflight && (edge_cnt <= commit_edge);
        if (rst || clr) begin
            if (busy_model && q.size() > 0) void'(q.pop_back());
            inflight   = 0;
            model_has  = 0;
            model_best = '0;
            exp_disp   = '0;
            exp_has    = 0;
            exp_ovf    = 0;
        end else if (req && !busy_model) begin
            ok = 1;
`ifdef RECORD_BEST_EN
            if (model_has && !(val < model_best)) ok = 0;
`endif
            if (ok) begin
                q.push_back('{to_bcd(val), (val > 24'd9999999), edge_cnt + 25});
                inflight    = 1;
                commit_edge = edge_cnt + 25;
                model_has   = 1;
                model_best  = val;
            end
        end
        $display("edge %0d: req=%0b val=%0d clr=%0b rst=%0b busy=%0b done=%0b", edge_cnt, req, val,
                 clr, rst, busy, rec_done);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 24'($urandom), 0, 0);
    endtask

    // Monitor: checks busy timing, commit timing/content and held display every cycle
    initial begin
        logic [27:0] leds_act;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                leds_act = {led7, led6, led5, led4, led3, led2, led1};
                chk("busy", int'(busy), int'(q.size() > 0 && edge_cnt < q[0].commit));
                if (rec_done) begin
                    if (q.size() == 0) begin
                        chk("unexpected_rec_done", 1, 0);
                    end else begin
                        chk("done_edge", edge_cnt, q[0].commit);
                        exp_disp = q[0].leds;
                        exp_ovf  = q[0].ovf;
                        exp_has  = 1;
                        void'(q.pop_front());
                    end
                end else if (q.size() > 0 && edge_cnt >= q[0].commit) begin
                    chk("missing_rec_done", 0, 1);
                    void'(q.pop_front());
                end
                chk("leds", int'(leds_act), int'(exp_disp));
                chk("has_record", int'(has_record), int'(exp_has));
                chk("overflow", int'(overflow), int'(exp_ovf));
            end
        end
    end

    initial begin
        repeat (3) step(0, '0, 0, 1);
        mon_en = 1;
        idle(2);
        // Basic conversion, zero, and saturation
        step(1, 24'd1234567, 0, 0); idle(30);
        step(1, 24'd0, 0, 0);       idle(30);
        step(1, 24'd16777215, 0, 0); idle(30);
        step(1, 24'd9999999, 0, 0); idle(30);
        step(1, 24'd10000000, 0, 0); idle(30);
        // Requests while busy are ignored
        step(1, 24'd42, 0, 0); idle(2);
        step(1, 24'd999, 0, 0); idle(6);
        step(1, 24'd777, 0, 0); idle(25);
        // Clear mid-conversion, then simultaneous request and clear
        step(1, 24'd555555, 0, 0); idle(10);
        step(0, 24'd0, 1, 0); idle(5);
        step(1, 24'd123, 1, 0); idle(30);
        // Best-record sequence
        step(1, 24'd5000, 0, 0); idle(30);
        step(1, 24'd6000, 0, 0); idle(30);
        step(1, 24'd4000, 0, 0); idle(30);
        // Reset mid-conversion, then a fresh request
        step(1, 24'd8888888, 0, 0); idle(8);
        step(0, 24'd0, 0, 1);
        step(1, 24'd7654321, 0, 0); idle(30);
        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int r;
            logic [23:0] v;
            r = int'($urandom_range(0, 99));
            v = ($urandom_range(0, 1) == 1) ? 24'($urandom_range(0, 9999999)) : 24'($urandom);
            step(r < 25, v, r == 99, r == 98);
        end
        idle(30);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
